// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment codes and bit order shared by the display scanner
package seg_pkg;
  typedef struct packed {
    logic dp, g, f, e, d, c, b, a;
  } seg_t;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_0 = 8'h3F;
  localparam logic [7:0] SEG_1 = 8'h06;
  localparam logic [7:0] SEG_2 = 8'h5B;
  localparam logic [7:0] SEG_3 = 8'h4F;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'h6D;
  localparam logic [7:0] SEG_6 = 8'h7D;
  localparam logic [7:0] SEG_7 = 8'h07;
  localparam logic [7:0] SEG_8 = 8'h7F;
  localparam logic [7:0] SEG_9 = 8'h6F;
  localparam logic [7:0] SEG_A = 8'h77;
  localparam logic [7:0] SEG_B = 8'h7C;
  localparam logic [7:0] SEG_C = 8'h39;
  localparam logic [7:0] SEG_D = 8'h5E;
  localparam logic [7:0] SEG_E = 8'h79;
  // code F is a dash: the hh-mm-ss separator
  localparam logic [7:0] SEG_F = 8'h40;
  localparam logic [7:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                          SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 4-bit digit code to {dp,g,f,e,d,c,b,a} segment pattern
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [7:0] seg
);
  assign seg = SEG_LUT[code];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: frame-snapshotted 2x4-digit seven-segment scanner with per-digit blink
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  blink_mask,
  output logic [7:0]  seg_data,
  output logic [7:0]  seg_data2,
  output logic [7:0]  seg_cs
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    idx;
  logic          blink_ph;
  logic [31:0]   snap;
  logic [7:0]    dec_hi, dec_lo;
  logic [3:0]    oh;
  logic          slot_end, blink_end;
  assign slot_end  = div_cnt == DW'(SCAN_DIV - 1);
  assign blink_end = blink_cnt == BW'(BLINK_DIV - 1);
  assign oh        = 4'b0001 << idx;
  seg_hex_decode u_dec_hi (.code(snap[{1'b1, idx, 2'b00} +: 4]), .seg(dec_hi));
  seg_hex_decode u_dec_lo (.code(snap[{1'b0, idx, 2'b00} +: 4]), .seg(dec_lo));
  // outputs are registered from the current counter state, so they lag it by one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      blink_cnt <= '0;
      idx       <= '0;
      blink_ph  <= 1'b0;
      snap      <= '0;
      seg_cs    <= '0;
      seg_data  <= SEG_BLANK;
      seg_data2 <= SEG_BLANK;
    end else begin
      div_cnt   <= slot_end ? '0 : div_cnt + 1'b1;
      blink_cnt <= blink_end ? '0 : blink_cnt + 1'b1;
      if (slot_end) idx <= idx + 1'b1;
      if (slot_end && idx == 2'd3) snap <= data;
      if (blink_end) blink_ph <= ~blink_ph;
      seg_cs    <= div_cnt < DW'(BLANK_CYC) ? '0 : {oh, oh};
      seg_data  <= blink_ph && blink_mask[{1'b1, idx}] ? SEG_BLANK : dec_hi;
      seg_data2 <= blink_ph && blink_mask[{1'b0, idx}] ? SEG_BLANK : dec_lo;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed vector check of the scanner with SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=64
module tb_seg_scan_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data = 32'h12F3_4F56;
  logic [7:0]  blink_mask = 8'h00;
  logic [7:0]  seg_data, seg_data2, seg_cs;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  typedef struct {
    int          n;
    logic [7:0]  cs, sd, sd2;
    logic [31:0] d;
    logic [7:0]  mk;
  } vec_t;
  vec_t vt[32];
  int   nv = 0;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .BLINK_DIV(64)) dut (
    .clk(clk), .rst(rst), .data(data), .blink_mask(blink_mask),
    .seg_data(seg_data), .seg_data2(seg_data2), .seg_cs(seg_cs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int at, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @m=%0d: got %h, expected %h", name, at, act, exp);
    end
  endtask

  // m is the counter-state cycle the outputs reflect; inputs d/mk are driven after the check
  task automatic add(input int m, input logic [7:0] cs, input logic [7:0] sd, input logic [7:0] sd2,
                     input logic [31:0] d, input logic [7:0] mk);
    vt[nv] = '{m + 1, cs, sd, sd2, d, mk};
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      while (cyc < vt[i].n) tick();
      chk("seg_cs", vt[i].n - 1, seg_cs, vt[i].cs);
      chk("seg_data", vt[i].n - 1, seg_data, vt[i].sd);
      chk("seg_data2", vt[i].n - 1, seg_data2, vt[i].sd2);
      data       = vt[i].d;
      blink_mask = vt[i].mk;
    end
  endtask

  initial begin
    add(0,   8'h00, 8'h3F, 8'h3F, 32'h12F3_4F56, 8'h00);
    add(1,   8'h00, 8'h3F, 8'h3F, 32'h12F3_4F56, 8'h00);
    add(2,   8'h11, 8'h3F, 8'h3F, 32'h12F3_4F56, 8'h00);
    add(10,  8'h22, 8'h3F, 8'h3F, 32'h12F3_4F56, 8'h00);
    add(31,  8'h88, 8'h3F, 8'h3F, 32'h12F3_4F56, 8'h00);
    add(32,  8'h00, 8'h4F, 8'h7D, 32'h12F3_4F56, 8'h00);
    add(33,  8'h00, 8'h4F, 8'h7D, 32'h12F3_4F56, 8'h00);
    add(34,  8'h11, 8'h4F, 8'h7D, 32'h12F3_4F56, 8'h00);
    add(39,  8'h11, 8'h4F, 8'h7D, 32'h12F3_4F56, 8'h00);
    add(40,  8'h00, 8'h40, 8'h6D, 32'h12F3_4F56, 8'h00);
    add(41,  8'h00, 8'h40, 8'h6D, 32'h12F3_4F56, 8'h00);
    add(42,  8'h22, 8'h40, 8'h6D, 32'h0000_0000, 8'h00);
    add(50,  8'h44, 8'h5B, 8'h40, 32'h0000_0000, 8'h00);
    add(58,  8'h88, 8'h06, 8'h66, 32'h0000_0000, 8'h00);
    add(63,  8'h88, 8'h06, 8'h66, 32'h0000_0000, 8'h00);
    add(64,  8'h00, 8'h3F, 8'h3F, 32'h0000_0000, 8'h00);
    add(65,  8'h00, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    add(66,  8'h11, 8'h3F, 8'h00, 32'h0000_0009, 8'h01);
    add(98,  8'h11, 8'h3F, 8'h00, 32'h0000_0009, 8'h01);
    add(106, 8'h22, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    add(127, 8'h88, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    add(128, 8'h00, 8'h3F, 8'h6F, 32'h0000_0009, 8'h01);
    add(130, 8'h11, 8'h3F, 8'h6F, 32'h0000_0009, 8'h01);
    add(138, 8'h22, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    add(191, 8'h88, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    add(192, 8'h00, 8'h3F, 8'h00, 32'h0000_0009, 8'h01);
    add(194, 8'h11, 8'h3F, 8'h00, 32'h0000_0009, 8'h01);
    add(211, 8'h44, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    add(0,   8'h00, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    add(2,   8'h11, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    add(10,  8'h22, 8'h3F, 8'h3F, 32'h0000_0009, 8'h01);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", -1, seg_cs, 8'h00);
    chk("rst_sd", -1, seg_data, 8'h00);
    chk("rst_sd2", -1, seg_data2, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    run(0, 28);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_cs", 211, seg_cs, 8'h00);
    chk("async_rst_sd", 211, seg_data, 8'h00);
    chk("async_rst_sd2", 211, seg_data2, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    run(28, nv);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

- Reader end of the 32-bit display-word interface produced by the time-keeping/key block.
- Takes eight 4-bit digit codes, snapshots them once per scan frame, and time-multiplexes them onto the board's 8-digit seven-segment display as two 4-digit groups.
- Supports per-digit blinking, so the setting cursor can be shown on the display.
- Sits between the clock/setting logic and the board pins.

## Interface

Parameters:
- `SCAN_DIV`, default 100_000: clock cycles per scan slot (1 kHz slot rate at 100 MHz); must be ≥ 2.
- `BLANK_CYC`, default 1_000: cycles at the start of each slot with all digit selects off (anti-ghosting); must be < `SCAN_DIV`.
- `BLINK_DIV`, default 25_000_000: cycles per blink half-period (2 Hz at 100 MHz); must be ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `data` in 32: digit k = `data[4k+3:4k]`; digit 7 is leftmost.
- `blink_mask` in 8: bit k = 1 makes digit k blink.
- `seg_data` out 8: segments for the left group (digits 7..4), active-high, bit order {dp,g,f,e,d,c,b,a}.
- `seg_data2` out 8: segments for the right group (digits 3..0), same encoding.
- `seg_cs` out 8: one-hot-per-group digit selects, active-high; bit k enables digit k.

## Operation

Counters and state:
- `div_cnt` counts 0..`SCAN_DIV`-1 and wraps.
- On wrap, `idx` (2 bits) advances 0→1→2→3→0.
- On the wrap where `idx` goes 3→0, `snap <= data`. `data` is sampled only then, so mid-frame changes never tear a frame.
- `blink_cnt` counts 0..`BLINK_DIV`-1. On wrap, `blink_ph` toggles.

Slot i (i = `idx`):
- While `div_cnt < BLANK_CYC`: `seg_cs = 0`.
- Otherwise: `seg_cs[i]` and `seg_cs[i+4]` are 1; all other bits are 0.
- `seg_data = dec(snap digit i+4)`; `seg_data2 = dec(snap digit i)`.
- If `blink_ph = 1` and `blink_mask[k] = 1`, the segment bus for digit k outputs 0x00. `seg_cs` is unaffected.
- `blink_mask` is sampled live, not snapshotted.

Decode table `dec` (dp always 0):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
- A=77, b=7C, C=39, d=5E, E=79, F=40 (dash, used as the hh-mm-ss separator)

## Timing

- All outputs are registered: each output reflects the counter state of the previous cycle (1-cycle latency).
- Reset (async assert, sync release by `clk` edge):
  - all counters, `idx`, `blink_ph` = 0;
  - `snap` = 0x0000_0000;
  - `seg_cs`, `seg_data`, `seg_data2` = 0x00.
- First frame after reset: displays all zeros, not `data`. The first `data` capture happens at the end of slot 3, at cycle 4·`SCAN_DIV`-1; it becomes visible from slot 0 of the second frame.
- Full frame period: 4·`SCAN_DIV` cycles. Each group is refreshed at `CLK`/(4·`SCAN_DIV`).
- `BLANK_CYC` = 0 is legal: no blanking.
- Simultaneous slot wrap and blink toggle: both apply in the same cycle. Output follows the new `idx` and the new `blink_ph`.
- Reset asserted mid-slot: outputs go to 0 immediately (asynchronous). The scan restarts at slot 0 with `snap` = 0.

## Structure

Shared package `seg_pkg`:
- the 16 segment-code constants;
- `SEG_BLANK` = 8'h00;
- the segment bit-order definition.

Sub-module `seg_hex_decode` (combinational, 4→8 bits, from `seg_pkg`), instantiated twice, once per group.

The counters, snapshot register and output registers live in the top module.

## Test plan

Bench parameters: `SCAN_DIV`=8, `BLANK_CYC`=2, `BLINK_DIV`=64.

1. Reset with `data` = 0x12F34F56 → all outputs 0x00 during reset. Frame 1 shows 3F on both buses. From frame 2, slot 0 gives `seg_cs` = 0x11, `seg_data` = 4F ('3'), `seg_data2` = 7D ('6').
2. Steady 0x12F34F56 → the slot sequence on `seg_cs` is 0x11, 0x22, 0x44, 0x88. `seg_data` shows 4F, 40, 5B, 06. `seg_data2` shows 7D, 6D, 40, 66.
3. Each slot → `seg_cs` = 0 for exactly 2 cycles, then active for 6 cycles. The segment buses stay valid throughout.
4. Change `data` to 0x00000000 during slot 1 → the current frame is unchanged. Zeros appear from the next slot 0.
5. `blink_mask` = 0x01, `data` = 0x00000009 → `seg_data2` in slot 0 alternates 6F / 00 every 64 cycles. Other digits never blank.
6. Assert `rst` in mid-slot 2 → outputs are 0x00 in the same cycle. After release, scanning restarts at `seg_cs` = 0x11 with all-zero digits.
